// File: rtl/cjb_addsub_pipe_v_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// The op encodings are also used by the ALU decode stage.
package cjb_addsub_pipe_v_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SLICE = 4;

    function automatic logic invert_y(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    // Subtraction without an explicit carry supplies the +1 of the two's complement.
    function automatic logic carry_in(input logic [1:0] op, input logic cin);
        logic use_cin;
        use_cin = (op == OP_ADC) || (op == OP_SBC);
        return use_cin ? cin : (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cjb_addsub_pipe_v_slice.sv
// Combinational W-bit ripple adder used as one pipeline stage of cjb_addsub_pipe_v.
// Also exposes the carry into the top bit so the last stage can derive signed overflow.
module cjb_addsub_slice_v
    import cjb_addsub_pipe_v_pkg::*;
#(
    parameter int W = DEFAULT_SLICE
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
    end

    assign cout  = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/cjb_addsub_pipe_v.sv
// Pipelined ADD/SUB/ADC/SBC unit: one SLICE-bit carry segment per register stage.
// WIDTH must be a multiple of SLICE; the whole pipe advances together under valid/ready.
module cjb_addsub_pipe_v
    import cjb_addsub_pipe_v_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int STAGES = WIDTH / SLICE;

    logic             advance;
    logic [WIDTH-1:0] y_eff;
    logic             c_in;

    // Stage registers
    logic             vq [STAGES];
    logic [WIDTH-1:0] xq [STAGES];
    logic [WIDTH-1:0] yq [STAGES];
    logic [WIDTH-1:0] sq [STAGES];
    logic             cq [STAGES];

    // Values feeding each stage (input port for stage 0, previous register otherwise)
    logic             vp [STAGES];
    logic [WIDTH-1:0] xp [STAGES];
    logic [WIDTH-1:0] yp [STAGES];
    logic [WIDTH-1:0] sp [STAGES];
    logic             cp [STAGES];

    logic [SLICE-1:0] ss   [STAGES];
    logic             sco  [STAGES];
    logic             smsb [STAGES];

    logic [WIDTH-1:0] result;

    assign y_eff     = invert_y(op) ? ~y : y;
    assign c_in      = carry_in(op, cin);
    assign out_valid = vq[STAGES-1];
    assign sum       = sq[STAGES-1];
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign vp[k] = in_valid;
            assign xp[k] = x;
            assign yp[k] = y_eff;
            assign sp[k] = '0;
            assign cp[k] = c_in;
        end else begin : g_body
            assign vp[k] = vq[k-1];
            assign xp[k] = xq[k-1];
            assign yp[k] = yq[k-1];
            assign sp[k] = sq[k-1];
            assign cp[k] = cq[k-1];
        end

        cjb_addsub_slice_v #(
            .W(SLICE)
        ) u_slice (
            .x    (xp[k][k*SLICE +: SLICE]),
            .y    (yp[k][k*SLICE +: SLICE]),
            .cin  (cp[k]),
            .sum  (ss[k]),
            .cout (sco[k]),
            .c_msb(smsb[k])
        );
    end

    // Full-width result entering the last register, used for the zero/negative flags.
    always_comb begin
        result                   = sp[STAGES-1];
        result[WIDTH-1 -: SLICE] = ss[STAGES-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                vq[k] <= 1'b0;
                xq[k] <= '0;
                yq[k] <= '0;
                sq[k] <= '0;
                cq[k] <= 1'b0;
            end
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vq[k]                    <= vp[k];
                xq[k]                    <= xp[k];
                yq[k]                    <= yp[k];
                sq[k]                    <= sp[k];
                sq[k][k*SLICE +: SLICE]  <= ss[k];
                cq[k]                    <= sco[k];
            end
            cout     <= sco[STAGES-1];
            overflow <= sco[STAGES-1] ^ smsb[STAGES-1];
            zero     <= (result == '0);
            negative <= result[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_cjb_addsub_pipe_v.sv
// Scoreboard bench for cjb_addsub_pipe_v (WIDTH=16, SLICE=4): directed flag cases,
// a stalled burst, random traffic and a mid-flight reset.
module tb_cjb_addsub_pipe_v;
    import cjb_addsub_pipe_v_pkg::*;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int STAGES = WIDTH / SLICE;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             cin;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
        int               issue;
        bit               chklat;
    } exp_t;

    exp_t        sb[$];
    int          tests;
    int          fails;
    int          cyc;
    bit          stalled_prev;
    logic [31:0] held;

    cjb_addsub_pipe_v #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .cin      (cin),
        .x        (x),
        .y        (y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        if (obs !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic on a widened sum; overflow from operand/result signs.
    function automatic exp_t model(input logic [1:0] o, input logic c,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t           e;
        logic [WIDTH-1:0] be;
        logic           ci;
        logic [WIDTH:0] full;
        be   = (o == OP_SUB || o == OP_SBC) ? ~b : b;
        ci   = (o == OP_ADC || o == OP_SBC) ? c : (o == OP_SUB);
        full = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, ci};
        e.sum    = full[WIDTH-1:0];
        e.cout   = full[WIDTH];
        e.zero   = (e.sum == '0);
        e.neg    = e.sum[WIDTH-1];
        e.ovf    = (a[WIDTH-1] == be[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
        e.issue  = 0;
        e.chklat = 1'b0;
        return e;
    endfunction

    // One clock cycle: drive at the falling edge, then check and score what the rising edge will transfer.
    task automatic applyStimulus(input logic iv, input logic [1:0] o, input logic c,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ordy, input bit lat, output bit accepted);
        exp_t e;
        @(negedge clock);
        in_valid  = iv;
        op        = o;
        cin       = c;
        x         = a;
        y         = b;
        out_ready = ordy;
        #1;
        cyc++;
        if (stalled_prev) begin
            checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("hold_result", {12'b0, sum, cout, overflow, zero, negative}, held);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                checkOutput("sum", {16'b0, sum}, {16'b0, e.sum});
                checkOutput("cout", {31'b0, cout}, {31'b0, e.cout});
                checkOutput("overflow", {31'b0, overflow}, {31'b0, e.ovf});
                checkOutput("zero", {31'b0, zero}, {31'b0, e.zero});
                checkOutput("negative", {31'b0, negative}, {31'b0, e.neg});
                if (e.chklat) checkOutput("latency", 32'(cyc - e.issue), 32'(STAGES));
            end
        end
        stalled_prev = out_valid && !out_ready;
        held         = {12'b0, sum, cout, overflow, zero, negative};
        accepted     = iv && in_ready;
        if (accepted) begin
            e        = model(o, c, a, b);
            e.issue  = cyc;
            e.chklat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic resetPipe();
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_sum", {16'b0, sum}, 32'd0);
        checkOutput("rst_cout", {31'b0, cout}, 32'd0);
        checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
        checkOutput("rst_zero", {31'b0, zero}, 32'd0);
        checkOutput("rst_negative", {31'b0, negative}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        sb.delete();
        stalled_prev = 1'b0;
    endtask

    task automatic directed(input logic [1:0] o, input logic c,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit acc;
        applyStimulus(1'b1, o, c, a, b, 1'b1, 1'b1, acc);
        checkOutput("directed_accept", {31'b0, acc}, 32'd1);
        repeat (STAGES + 1) applyStimulus(1'b0, OP_ADD, 1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && sb.size() > 0; i++)
            applyStimulus(1'b0, OP_ADD, 1'b0, '0, '0, 1'b1, 1'b0, acc);
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [1:0]       bo [8];
        logic             bc [8];
        logic [WIDTH-1:0] bx [8];
        logic [WIDTH-1:0] by [8];
        bit               acc;
        int               idx;
        int               k;

        tests = 0; fails = 0; cyc = 0; stalled_prev = 1'b0; held = '0;
        reset = 1'b1; in_valid = 1'b0; op = OP_ADD; cin = 1'b0;
        x = '0; y = '0; out_ready = 1'b1;

        resetPipe();
        checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);

        directed(OP_ADD, 1'b0, 16'h7FFF, 16'h0001);
        directed(OP_SUB, 1'b0, 16'h0005, 16'h0005);
        directed(OP_SUB, 1'b0, 16'h0000, 16'h0001);
        directed(OP_ADD, 1'b0, 16'hFFFF, 16'h0001);
        directed(OP_ADC, 1'b1, 16'h00FF, 16'h0000);
        directed(OP_SBC, 1'b1, 16'h8000, 16'h0001);
        directed(OP_ADD, 1'b1, 16'h1234, 16'h1111);
        directed(OP_SUB, 1'b1, 16'h8000, 16'h0001);
        directed(OP_SBC, 1'b0, 16'h0000, 16'h0000);

        // Back-to-back burst with the consumer stalling in cycles 5..7
        for (int i = 0; i < 8; i++) begin
            bo[i] = 2'($urandom_range(0, 3));
            bc[i] = 1'($urandom_range(0, 1));
            bx[i] = 16'($urandom);
            by[i] = 16'($urandom);
        end
        idx = 0;
        k   = 0;
        while ((idx < 8 || sb.size() > 0) && k < 40) begin
            if (idx < 8)
                applyStimulus(1'b1, bo[idx], bc[idx], bx[idx], by[idx],
                              !(k >= 5 && k <= 7), (k == 0), acc);
            else
                applyStimulus(1'b0, OP_ADD, 1'b0, '0, '0, 1'b1, 1'b0, acc);
            if (k >= 5 && k <= 7) checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
            if (k < 5) checkOutput("flow_in_ready", {31'b0, in_ready}, 32'd1);
            if (acc) idx++;
            k++;
        end
        checkOutput("burst_issued", 32'(idx), 32'd8);
        checkOutput("burst_drained", 32'(sb.size()), 32'd0);

        // Random traffic with random back-pressure
        for (int i = 0; i < 80; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                          ($urandom_range(0, 9) < 7), 1'b0, acc);
        end
        drain();

        // Reset while three operations are in flight
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, OP_ADD, 1'b0, 16'(i + 1), 16'h0101, 1'b1, 1'b0, acc);
        resetPipe();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, OP_ADD, 1'b0, '0, '0, 1'b1, 1'b0, acc);
            checkOutput("no_stale", {31'b0, out_valid}, 32'd0);
        end

        directed(OP_ADD, 1'b0, 16'h0FFF, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
